// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for data_mem_arbiter: two master request/ready ports and the
// shared ext_mem port. slave = arbiter side, master = requesters/memory side.
interface data_mem_arbiter_if;
    logic        m0_req_i;
    logic        m0_we_i;
    logic [3:0]  m0_be_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_wd_i;
    logic [31:0] m0_rd_o;
    logic        m0_ready_o;

    logic        m1_req_i;
    logic        m1_we_i;
    logic [3:0]  m1_be_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_wd_i;
    logic [31:0] m1_rd_o;
    logic        m1_ready_o;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;
    logic        timeout_o;

    modport slave (
        input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wd_i,
        output m0_rd_o, m0_ready_o,
        input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wd_i,
        output m1_rd_o, m1_ready_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        input  mem_rd_i, mem_ready_i,
        output timeout_o
    );

    modport master (
        output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wd_i,
        input  m0_rd_o, m0_ready_o,
        output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wd_i,
        input  m1_rd_o, m1_ready_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        output mem_rd_i, mem_ready_i,
        input  timeout_o
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-master data-memory arbiter: one outstanding transaction, round-robin
// (or fixed priority with DATA_MEM_ARB_FIXED_PRIO_EN), watchdog completion.
// Ports: clk_i, rst_i (async, active-low), bus (data_mem_arbiter_if.slave).
// Parameter TIMEOUT (>=2): BUSY cycles without mem_ready_i before the
// watchdog completes the transaction with 32'hDEAD_BEEF and timeout_o.
module data_mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    data_mem_arbiter_if.slave   bus
);

    typedef enum logic {IDLE, BUSY} state_e;

    localparam int unsigned    CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [31:0]    ERR_DATA = 32'hDEAD_BEEF;

    state_e         state_q, state_d;
    logic           grant_q, grant_d;
    logic           last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           g_req;
    logic           g_we;
    logic [3:0]     g_be;
    logic [31:0]    g_addr;
    logic [31:0]    g_wd;
    logic           tie_pick;
    logic           done;
    logic           tmo;
    logic [31:0]    rd_val;

    assign g_req  = grant_q ? bus.m1_req_i  : bus.m0_req_i;
    assign g_we   = grant_q ? bus.m1_we_i   : bus.m0_we_i;
    assign g_be   = grant_q ? bus.m1_be_i   : bus.m0_be_i;
    assign g_addr = grant_q ? bus.m1_addr_i : bus.m0_addr_i;
    assign g_wd   = grant_q ? bus.m1_wd_i   : bus.m0_wd_i;

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    assign tie_pick = 1'b0;
`else
    // Tie goes to whoever was not served last.
    assign tie_pick = ~last_q;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        done           = 1'b0;
        tmo            = 1'b0;
        rd_val         = '0;
        bus.mem_req_o  = 1'b0;
        bus.mem_we_o   = 1'b0;
        bus.mem_be_o   = '0;
        bus.mem_addr_o = '0;
        bus.mem_wd_o   = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.m0_req_i || bus.m1_req_i) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    if (bus.m0_req_i && bus.m1_req_i) begin
                        grant_d = tie_pick;
                    end else begin
                        grant_d = bus.m1_req_i;
                    end
                end
            end
            BUSY: begin
                bus.mem_req_o  = g_req;
                bus.mem_we_o   = g_we;
                bus.mem_be_o   = g_be;
                bus.mem_addr_o = g_addr;
                bus.mem_wd_o   = g_wd;
                if (!g_req) begin
                    // Owner withdrew: drop silently, keep round-robin history.
                    state_d = IDLE;
                end else if (bus.mem_ready_i) begin
                    done    = 1'b1;
                    rd_val  = bus.mem_rd_i;
                    state_d = IDLE;
                    last_d  = grant_q;
                end else if (cnt_q == CNT_LAST) begin
                    done    = 1'b1;
                    tmo     = 1'b1;
                    rd_val  = ERR_DATA;
                    state_d = IDLE;
                    last_d  = grant_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    assign bus.m0_ready_o = done & ~grant_q;
    assign bus.m1_ready_o = done &  grant_q;
    assign bus.m0_rd_o    = (done & ~grant_q) ? rd_val : '0;
    assign bus.m1_rd_o    = (done &  grant_q) ? rd_val : '0;
    assign bus.timeout_o  = tmo;

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-master arbiter that shares the single data-memory port (`ext_mem` request/ready protocol) between the core's LSU (master 0) and a second bus master such as a DMA or debug unit (master 1). It sits between the LSU memory-side port and `ext_mem`. It grants one outstanding transaction at a time and routes `ready`/read data back to the owner. A watchdog completes stuck transactions with an error value.

## Interface
- `TIMEOUT`, 16, number of BUSY cycles without `mem_ready_i` before forced completion; must be ≥2.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `mN_req_i` (N=0,1)  in  1  master N request; held high until its `mN_ready_o` pulse.
- `mN_we_i`  in  1  master N write enable.
- `mN_be_i`  in  4  master N byte enables.
- `mN_addr_i`  in  32  master N byte address.
- `mN_wd_i`  in  32  master N write data.
- `mN_rd_o`  out  32  read data to master N; valid only while `mN_ready_o`=1, otherwise 0.
- `mN_ready_o`  out  1  one-cycle completion pulse to master N.
- `mem_req_o`  out  1  request to memory.
- `mem_we_o`, `mem_be_o`[3:0], `mem_addr_o`[31:0], `mem_wd_o`[31:0]  out  fields forwarded from the granted master; 0 when not BUSY.
- `mem_rd_i`  in  32  memory read data.
- `mem_ready_i`  in  1  memory completion.
- `timeout_o`  out  1  one-cycle pulse on watchdog completion.

## Operation
- FSM states: IDLE, BUSY. Registers: `state_q`, `grant_q` (1 bit), `last_q` (1 bit, master served last), `cnt_q` ($clog2(TIMEOUT)+1 bits).
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one `mN_req_i`=1, set `grant_q`=N and go to BUSY.
  - If both request, grant the master ≠ `last_q` (round-robin).
  - On entering BUSY, clear `cnt_q`.
- BUSY, granted master g:
  - `mem_req_o` = `mg_req_i`.
  - Memory fields are muxed combinationally from master g.
- BUSY, completion on `mem_ready_i`=1:
  - `mg_ready_o`=1 and `mg_rd_o`=`mem_rd_i` in the same cycle (combinational).
  - Next state IDLE, `last_q`←g.
- BUSY, watchdog:
  - While `mem_ready_i`=0, `cnt_q` increments each cycle.
  - When `cnt_q`==TIMEOUT-1 and `mem_ready_i`=0: `mg_ready_o`=1, `mg_rd_o`=32'hDEAD_BEEF, `timeout_o`=1; next state IDLE, `last_q`←g.
  - If `mem_ready_i` and timeout coincide, the normal completion wins and `timeout_o`=0.
- BUSY, abort:
  - If `mg_req_i` falls before completion (protocol violation), `mem_req_o` drops the same cycle.
  - Next state IDLE with no ready pulse; `last_q` is unchanged.
- The non-granted master sees `ready`=0 and `rd`=0 and keeps waiting. Its request is evaluated on the next IDLE cycle.

## Timing
- Reset (`rst_i`=0, any time, including mid-transaction):
  - Immediately: `state_q`=IDLE, `grant_q`=0, `last_q`=1 (master 0 wins the first tie), `cnt_q`=0.
  - All outputs are 0.
  - An in-flight transaction is dropped with no ready pulse.
- Latency: request seen in IDLE at cycle N → `mem_req_o`=1 at N+1. With `mem_ready_i`=1 at N+1, `mN_ready_o` also pulses at N+1.
- Throughput: at least 2 cycles per transaction (the mandatory IDLE cycle); a busy master issues at most one transaction per 2 cycles.
- Under continuous contention, grants strictly alternate 0,1,0,1.
- Watchdog fires on the TIMEOUT-th BUSY cycle (cycle N+TIMEOUT for a grant at N).

## Configuration
- `DATA_MEM_ARB_FIXED_PRIO_EN`:
  - Defined: master 0 always wins simultaneous requests. `last_q` is still updated but ignored for arbitration.
  - Undefined (default): round-robin as above.

## Test plan
- Single read: m0 read, addr 0x10, memory returns 0x12345678 with ready at the first BUSY cycle → `mem_req_o` at N+1; `m0_ready_o` pulse and `m0_rd_o`=0x12345678 at N+1; next cycle IDLE.
- Contention after reset: both masters request at cycle 0 and stay requesting → grants m0, m1, m0, m1 on each transaction. With FIXED_PRIO_EN: m0, m0, m0, and m1 starves until m0 drops its request.
- Write forwarding: m1 write, addr 0x20, wd 0xA5A5A5A5, be 4'b0011 → memory sees exactly these values with `mem_we_o`=1; `m0_ready_o` stays 0.
- Watchdog: TIMEOUT=16, `mem_ready_i` held 0 → 16th BUSY cycle gives `m0_ready_o`=1, `m0_rd_o`=0xDEADBEEF, `timeout_o`=1; then IDLE.
- Reset mid-transaction: `rst_i`=0 at the 3rd BUSY cycle → all outputs 0 immediately, no ready pulse. After release, m0 wins a simultaneous request.
- Abort: m1 drops its request at the 2nd BUSY cycle → `mem_req_o`=0 that cycle, no `m1_ready_o`, IDLE next cycle.
